cam_pwr_seq: RTL



---
 rtl/cam_pwr_seq_pkg.sv | 23 ++
 rtl/cam_pwr_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and default timing for the camera power/reset sequencer.
package cam_pwr_seq_pkg;

  typedef logic [19:0] pwr_tick_t;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    CAM_UP = 2'd1,
    RUN    = 2'd2,
    I2C_DN = 2'd3
  } pwr_state_t;

  // Counts of 2.5 us strobes: 2 s off, 2 s camera settle, 1 ms I2C quiesce.
  localparam int unsigned PWR_OFF_TICKS   = 800000;
  localparam int unsigned PWR_CAMUP_TICKS = 800000;
  localparam int unsigned PWR_I2CDN_TICKS = 400;

  // Terminal counter value for an N-tick state; N may be 2^20.
  function automatic pwr_tick_t tick_last(input int unsigned n);
    return pwr_tick_t'(n - 1);
  endfunction

endpackage

// File: rtl/cam_pwr_seq.sv
// Camera power/reset sequencer: cold power-up, and ordered power-down/up on
// restart request or while shutdown is held.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int unsigned OFF_TICKS    = PWR_OFF_TICKS,
  parameter int unsigned CAM_UP_TICKS = PWR_CAMUP_TICKS,
  parameter int unsigned I2C_DN_TICKS = PWR_I2CDN_TICKS
) (
  input  logic       clk_100,
  input  logic       srst0,
  input  logic       strobe_400kHz,
  input  logic       restart_req,
  input  logic       shutdown,
  output logic       cam_en,
  output logic       i2c_areset_n,
  output logic       busy,
  output logic       up_done,
  output logic [7:0] restart_cnt
);

  localparam logic [1:0] S_OFF    = OFF;
  localparam logic [1:0] S_CAM_UP = CAM_UP;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_I2C_DN = I2C_DN;

  localparam pwr_tick_t OFF_LAST   = tick_last(OFF_TICKS);
  localparam pwr_tick_t CAMUP_LAST = tick_last(CAM_UP_TICKS);
  localparam pwr_tick_t I2CDN_LAST = tick_last(I2C_DN_TICKS);

  logic [1:0] state;
  pwr_tick_t  cnt;

  // Counter is cleared on every transition, so the strobe on the entry edge
  // is never counted towards the new state.
  always_ff @(posedge clk_100 or posedge srst0) begin
    if (srst0) begin
      state        <= S_OFF;
      cnt          <= '0;
      cam_en       <= 1'b0;
      i2c_areset_n <= 1'b0;
      busy         <= 1'b1;
      up_done      <= 1'b0;
      restart_cnt  <= 8'd0;
    end else begin
      up_done <= 1'b0;
      case (state)
        S_OFF: begin
          if (shutdown) begin
            cnt <= '0;
          end else if (strobe_400kHz) begin
            if (cnt == OFF_LAST) begin
              state  <= S_CAM_UP;
              cnt    <= '0;
              cam_en <= 1'b1;
            end else begin
              cnt <= cnt + 20'd1;
            end
          end
        end
        S_CAM_UP: begin
          if (shutdown) begin
            state  <= S_OFF;
            cnt    <= '0;
            cam_en <= 1'b0;
          end else if (strobe_400kHz) begin
            if (cnt == CAMUP_LAST) begin
              state        <= S_RUN;
              cnt          <= '0;
              i2c_areset_n <= 1'b1;
              busy         <= 1'b0;
              up_done      <= 1'b1;
            end else begin
              cnt <= cnt + 20'd1;
            end
          end
        end
        S_RUN: begin
          if (shutdown || restart_req) begin
            state        <= S_I2C_DN;
            cnt          <= '0;
            i2c_areset_n <= 1'b0;
            busy         <= 1'b1;
          end else if (strobe_400kHz) begin
            cnt <= cnt + 20'd1;
          end
          // A coincident shutdown wins and is not counted as a restart.
          if (restart_req && !shutdown && restart_cnt != 8'hff)
            restart_cnt <= restart_cnt + 8'd1;
        end
        S_I2C_DN: begin
          if (strobe_400kHz) begin
            if (cnt == I2CDN_LAST) begin
              state  <= S_OFF;
              cnt    <= '0;
              cam_en <= 1'b0;
            end else begin
              cnt <= cnt + 20'd1;
            end
          end
        end
        default: begin
          state        <= S_OFF;
          cnt          <= '0;
          cam_en       <= 1'b0;
          i2c_areset_n <= 1'b0;
          busy         <= 1'b1;
        end
      endcase
    end
  end

endmodule
